spi_sample_scheduler: RTL and testbench
=======================================

# spi_sample_scheduler

Controller that sequences the Arduino SPI link into the sample datapath: it samples the raw SPI pins in the CLK_50Mhz domain, frames and validates 16-bit words, pairs frequency and amplitude words into sample entries, buffers them in a small FIFO and releases one entry per playback tick. It sits between the Arduino SPI pins and the tone-generation logic that consumes outputFrequencySample/outputAmplitudeSample.

## Interface
- FIFO_DEPTH, 4: sample-pair FIFO entries, power of two, ≥2
- SYNC_STAGES, 2: synchronizer flops per SPI pin, ≥2
- CLK_50Mhz  in  1  system clock; all logic on its rising edge
- reset_n  in  1  synchronous, active-low reset
- input_SPI_SCLK  in  1  asynchronous SPI clock; data is valid on its rising edge
- input_SPI_CS_n  in  1  asynchronous chip select, active low
- input_SPI_SDO  in  1  asynchronous serial data, MSB first
- sampleTick  in  1  one-cycle playback strobe (1 kHz rate)
- outputFrequencySample  out  14  current frequency; reset 0
- outputAmplitudeSample  out  8  current amplitude; reset 0
- outputValid  out  1  one-cycle pulse when outputs load; reset 0
- fifoLevel  out  $clog2(FIFO_DEPTH)+1  entries held; reset 0
- overflowFlag  out  1  sticky; reset 0
- frameErrorFlag  out  1  sticky; reset 0
- inputLight  out  1  high while state is SHIFT; reset 0

## Operation
- Synchronizers: reset values SCLK 0, CS_n 1, SDO 0. Edges are detected on the last synchronizer stage against one extra registered copy.
- FSM states: WAIT_IDLE (reset state), IDLE, SHIFT, CHECK.
- WAIT_IDLE: go to IDLE once synced CS_n = 1, so a frame already in progress at reset release is ignored.
- IDLE: on a synced CS_n falling edge, clear the 16-bit shift register and the 5-bit bit counter, then go to SHIFT.
- SHIFT: on each synced SCLK rising edge, do shift = {shift[14:0], SDO} and increment the counter, saturating at 17.
  - On a synced CS_n rising edge: counter == 16 goes to CHECK; any other count sets frameErrorFlag, discards the word and goes to IDLE.
  - An SCLK rise in the same cycle as the CS_n rise is ignored.
- CHECK (one cycle), then IDLE:
  - bit15 = 0 (frequency word): bit14 must be 0. Load pendingFreq = bits[13:0] and set pendingValid. A second frequency word overwrites the pending value.
  - bit15 = 1 (amplitude word): bits[14:8] must be 0. Push {freq, bits[7:0]}, where freq = pendingFreq if pendingValid, else lastPushedFreq (reset 0). Clear pendingValid and update lastPushedFreq.
  - Reserved-bit violation: set frameErrorFlag, make no state change.
- FIFO:
  - A push while full is dropped and sets overflowFlag, unless a pop occurs in the same cycle; then the push is accepted and the level is unchanged.
  - A push and a pop in the same cycle when not full: both happen, level unchanged.
  - No bypass: a push and a tick on an empty FIFO leaves the outputs holding; the new entry waits for the next tick.
- sampleTick with FIFO non-empty: pop the head into the output registers and pulse outputValid. With FIFO empty: outputs hold and outputValid stays 0.
- Sticky flags clear only on reset. Reset mid-operation clears the FIFO, pending state and all outputs, and returns to WAIT_IDLE.

## Timing
- Pin-to-detect latency is SYNC_STAGES+1 cycles. SCLK high and low phases must each be ≥ SYNC_STAGES+2 CLK_50Mhz cycles (SCLK ≤ 6.25 MHz at defaults).
- CS_n setup: first SCLK rise ≥ SYNC_STAGES+2 cycles after the CS_n fall. The same applies to the last SCLK rise before the CS_n rise.
- FIFO push happens in the CHECK cycle, which is the cycle after the CS_n rise is detected. fifoLevel reflects the push on the following cycle.
- sampleTick sampled high in cycle T: outputs load and outputValid = 1 in cycle T+1 only.
- Frames may be back-to-back with CS_n high for ≥ SYNC_STAGES+2 cycles.

## Test plan
- Frame 0x0ABC then 0x8040, then a tick -> cycle after the tick: outputFrequencySample = 0x0ABC, outputAmplitudeSample = 0x40, outputValid high for exactly 1 cycle, fifoLevel 1→0.
- 12-bit frame, then an 18-SCLK frame, then 0x4001 -> frameErrorFlag = 1 after the first frame, fifoLevel stays 0, outputs unchanged.
- Five pairs (freq 1..5, amp 0x10..0x50) with no tick -> fifoLevel = 4, overflowFlag = 1; four ticks return freq 1..4 in order, and a fifth tick gives no outputValid.
- Pair 0x0100/0x8011, then amplitude-only 0x80FF -> two entries: {0x0100,0x11} and {0x0100,0xFF}.
- FIFO full, with a push and a tick in the same cycle -> overflowFlag stays 0, fifoLevel stays 4, the head entry is output.
- reset_n asserted for 2 cycles mid-frame while CS_n is held low; remaining bits sent; then a clean frame pair 0x0123/0x8077 -> no push from the interrupted frame, frameErrorFlag = 0, one entry {0x0123,0x77}.

Source files
------------

// File: rtl/spi_sample_scheduler_if.sv
// rtl/spi_sample_scheduler_if.sv - SPI pin / sample output bundle for spi_sample_scheduler
interface spi_sample_scheduler_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          input_SPI_SCLK;
    logic          input_SPI_CS_n;
    logic          input_SPI_SDO;
    logic          sampleTick;
    logic [13:0]   outputFrequencySample;
    logic [7:0]    outputAmplitudeSample;
    logic          outputValid;
    logic [LW-1:0] fifoLevel;
    logic          overflowFlag;
    logic          frameErrorFlag;
    logic          inputLight;

    modport master (
        output input_SPI_SCLK, input_SPI_CS_n, input_SPI_SDO, sampleTick,
        input  outputFrequencySample, outputAmplitudeSample, outputValid,
               fifoLevel, overflowFlag, frameErrorFlag, inputLight
    );

    modport slave (
        input  input_SPI_SCLK, input_SPI_CS_n, input_SPI_SDO, sampleTick,
        output outputFrequencySample, outputAmplitudeSample, outputValid,
               fifoLevel, overflowFlag, frameErrorFlag, inputLight
    );
endinterface

// File: rtl/spi_sample_scheduler.sv
// rtl/spi_sample_scheduler.sv - SPI word framer, freq/amp pairing, sample FIFO and tick release
module spi_sample_scheduler #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK_50Mhz,
    input  logic                  reset_n,
    spi_sample_scheduler_if.slave bus
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [4:0]    SETTLE = 5'(SYNC_STAGES);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, CHECK} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, sdo_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic [15:0]            shift_q;
    logic [4:0]             cnt_q;
    logic [13:0]            pend_freq_q, last_freq_q;
    logic                   pend_valid_q;
    logic [21:0]            mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]          level_q;
    logic [13:0]            out_freq_q;
    logic [7:0]             out_amp_q;
    logic                   out_valid_q, ovf_q, ferr_q;

    logic sclk_s, cs_s, sdo_s, sclk_rise, cs_rise, cs_fall;
    logic shift_clr, shift_en, len_err, do_check;
    logic freq_ok, amp_ok, check_err, push, pop, push_acc, full, empty;
    logic [21:0] push_data;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sdo_s     = sdo_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    // Pin synchronizers plus one registered copy for edge detection
    always_ff @(posedge CLK_50Mhz) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            sdo_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.input_SPI_SCLK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.input_SPI_CS_n};
            sdo_sync_q  <= {sdo_sync_q[SYNC_STAGES-2:0], bus.input_SPI_SDO};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    // Frame FSM state register
    always_ff @(posedge CLK_50Mhz) begin
        if (!reset_n) state_q <= WAIT_IDLE;
        else          state_q <= state_d;
    end

    // Frame FSM next state and strobes; WAIT_IDLE lets the synchronizers flush
    // their reset value so a frame already in flight is not mistaken for idle
    always_comb begin
        state_d   = state_q;
        shift_clr = 1'b0;
        shift_en  = 1'b0;
        len_err   = 1'b0;
        do_check  = 1'b0;
        case (state_q)
            WAIT_IDLE: if (cnt_q >= SETTLE && cs_s) state_d = IDLE;
            IDLE: if (cs_fall) begin
                shift_clr = 1'b1;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (cs_rise) begin
                    if (cnt_q == 5'd16) state_d = CHECK;
                    else begin
                        len_err = 1'b1;
                        state_d = IDLE;
                    end
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                end
            end
            CHECK: begin
                do_check = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    assign freq_ok   = do_check & ~shift_q[15] & ~shift_q[14];
    assign amp_ok    = do_check & shift_q[15] & (shift_q[14:8] == 7'd0);
    assign check_err = do_check & ~freq_ok & ~amp_ok;
    assign push      = amp_ok;
    assign push_data = {(pend_valid_q ? pend_freq_q : last_freq_q), shift_q[7:0]};
    assign full      = (level_q == FULL_LEVEL);
    assign empty     = (level_q == '0);
    assign pop       = bus.sampleTick & ~empty;
    assign push_acc  = push & (~full | pop);

    // Shift register, bit counter (doubles as settle counter in WAIT_IDLE), pairing state
    always_ff @(posedge CLK_50Mhz) begin
        if (!reset_n) begin
            shift_q      <= '0;
            cnt_q        <= '0;
            pend_freq_q  <= '0;
            pend_valid_q <= 1'b0;
            last_freq_q  <= '0;
            ferr_q       <= 1'b0;
        end else begin
            if (state_q == WAIT_IDLE && cnt_q < SETTLE) cnt_q <= cnt_q + 5'd1;
            if (shift_clr) begin
                shift_q <= '0;
                cnt_q   <= '0;
            end else if (shift_en) begin
                shift_q <= {shift_q[14:0], sdo_s};
                if (cnt_q != 5'd17) cnt_q <= cnt_q + 5'd1;
            end
            if (freq_ok) begin
                pend_freq_q  <= shift_q[13:0];
                pend_valid_q <= 1'b1;
            end
            if (amp_ok) begin
                pend_valid_q <= 1'b0;
                last_freq_q  <= push_data[21:8];
            end
            if (len_err || check_err) ferr_q <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge CLK_50Mhz) begin
        if (push_acc) mem_q[wr_ptr_q] <= push_data;
    end

    // FIFO pointers, level, overflow and output registers
    always_ff @(posedge CLK_50Mhz) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
            out_freq_q  <= '0;
            out_amp_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (push_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_acc && !pop)      level_q <= level_q + 1'b1;
            else if (pop && !push_acc) level_q <= level_q - 1'b1;
            if (push && full && !pop) ovf_q <= 1'b1;
            out_valid_q <= pop;
            if (pop) {out_freq_q, out_amp_q} <= mem_q[rd_ptr_q];
        end
    end

    assign bus.outputFrequencySample = out_freq_q;
    assign bus.outputAmplitudeSample = out_amp_q;
    assign bus.outputValid           = out_valid_q;
    assign bus.fifoLevel             = level_q;
    assign bus.overflowFlag          = ovf_q;
    assign bus.frameErrorFlag        = ferr_q;
    assign bus.inputLight            = (state_q == SHIFT);
endmodule

// File: tb/tb_spi_sample_scheduler.sv
// tb/tb_spi_sample_scheduler.sv - directed-vector bench for spi_sample_scheduler
module tb_spi_sample_scheduler;
    localparam int H   = 6;
    localparam int GAP = 8;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    spi_sample_scheduler_if #(.FIFO_DEPTH(4)) bus ();

    spi_sample_scheduler #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .CLK_50Mhz (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.input_SPI_SCLK = 1'b0;
        bus.input_SPI_CS_n = 1'b1;
        bus.input_SPI_SDO  = 1'b0;
        bus.sampleTick     = 1'b0;
        reset_n = 1'b0;
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(5);
    endtask

    task automatic cs_low();
        bus.input_SPI_CS_n = 1'b0;
        wait_cyc(H);
    endtask

    task automatic spi_bit(input logic b);
        bus.input_SPI_SDO  = b;
        bus.input_SPI_SCLK = 1'b0;
        wait_cyc(H);
        bus.input_SPI_SCLK = 1'b1;
        wait_cyc(H);
    endtask

    // CS_n rises; optional tick lands in the CHECK cycle (pin rise + 3 edges)
    task automatic cs_high(input bit tick_on_push);
        bus.input_SPI_SCLK = 1'b0;
        wait_cyc(H);
        bus.input_SPI_CS_n = 1'b1;
        if (tick_on_push) begin
            wait_cyc(3);
            bus.sampleTick = 1'b1;
            @(negedge clk);
            bus.sampleTick = 1'b0;
            chk("simul_valid", 32'(bus.outputValid), 32'd1);
            chk("simul_freq", 32'(bus.outputFrequencySample), 32'h21);
            chk("simul_amp", 32'(bus.outputAmplitudeSample), 32'h01);
        end
        wait_cyc(GAP);
    endtask

    task automatic send_frame(input logic [31:0] word, input int nbits, input bit tick_on_push);
        cs_low();
        for (int i = nbits - 1; i >= 0; i--) spi_bit(word[i]);
        cs_high(tick_on_push);
    endtask

    task automatic send_pair(input logic [13:0] f, input logic [7:0] a);
        send_frame({18'd0, f}, 16, 1'b0);
        send_frame({16'd0, 8'h80, a}, 16, 1'b0);
    endtask

    task automatic tick_expect(input string tag, input bit valid, input logic [13:0] f, input logic [7:0] a);
        bus.sampleTick = 1'b1;
        @(negedge clk);
        bus.sampleTick = 1'b0;
        chk({tag, "_valid"}, 32'(bus.outputValid), 32'(valid));
        chk({tag, "_freq"}, 32'(bus.outputFrequencySample), 32'(f));
        chk({tag, "_amp"}, 32'(bus.outputAmplitudeSample), 32'(a));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(bus.outputValid), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        do_reset();

        chk("rst_freq", 32'(bus.outputFrequencySample), 32'd0);
        chk("rst_amp", 32'(bus.outputAmplitudeSample), 32'd0);
        chk("rst_valid", 32'(bus.outputValid), 32'd0);
        chk("rst_level", 32'(bus.fifoLevel), 32'd0);
        chk("rst_ovf", 32'(bus.overflowFlag), 32'd0);
        chk("rst_ferr", 32'(bus.frameErrorFlag), 32'd0);
        chk("rst_light", 32'(bus.inputLight), 32'd0);

        // basic pair then one tick
        cs_low();
        spi_bit(1'b0);
        chk("light_shift", 32'(bus.inputLight), 32'd1);
        for (int i = 14; i >= 0; i--) spi_bit(1'(16'h0ABC >> i));
        cs_high(1'b0);
        send_frame(32'h8040, 16, 1'b0);
        chk("basic_level1", 32'(bus.fifoLevel), 32'd1);
        tick_expect("basic", 1'b1, 14'h0ABC, 8'h40);
        chk("basic_level0", 32'(bus.fifoLevel), 32'd0);
        chk("basic_ferr", 32'(bus.frameErrorFlag), 32'd0);

        // framing errors
        send_frame(32'h0ABC, 12, 1'b0);
        chk("err12_ferr", 32'(bus.frameErrorFlag), 32'd1);
        send_frame(32'h2AAAA, 18, 1'b0);
        send_frame(32'h4001, 16, 1'b0);
        chk("err_level", 32'(bus.fifoLevel), 32'd0);
        chk("err_freq", 32'(bus.outputFrequencySample), 32'h0ABC);
        chk("err_amp", 32'(bus.outputAmplitudeSample), 32'h40);
        tick_expect("err_empty", 1'b0, 14'h0ABC, 8'h40);

        // overflow with five pairs
        do_reset();
        for (int k = 1; k <= 5; k++) send_pair(14'(k), 8'(k * 16));
        chk("ovf_level", 32'(bus.fifoLevel), 32'd4);
        chk("ovf_flag", 32'(bus.overflowFlag), 32'd1);
        for (int k = 1; k <= 4; k++) tick_expect($sformatf("ovf_pop%0d", k), 1'b1, 14'(k), 8'(k * 16));
        tick_expect("ovf_pop5", 1'b0, 14'd4, 8'h40);

        // amplitude-only reuses last pushed frequency
        do_reset();
        send_pair(14'h0100, 8'h11);
        send_frame(32'h80FF, 16, 1'b0);
        chk("reuse_level", 32'(bus.fifoLevel), 32'd2);
        tick_expect("reuse_a", 1'b1, 14'h0100, 8'h11);
        tick_expect("reuse_b", 1'b1, 14'h0100, 8'hFF);

        // push into a full FIFO with a simultaneous tick
        do_reset();
        for (int k = 1; k <= 4; k++) send_pair(14'(32 + k), 8'(k));
        chk("simul_full", 32'(bus.fifoLevel), 32'd4);
        send_frame(32'h0025, 16, 1'b0);
        send_frame(32'h8005, 16, 1'b1);
        chk("simul_ovf", 32'(bus.overflowFlag), 32'd0);
        chk("simul_level", 32'(bus.fifoLevel), 32'd4);
        tick_expect("simul_p2", 1'b1, 14'h22, 8'h02);
        tick_expect("simul_p3", 1'b1, 14'h23, 8'h03);
        tick_expect("simul_p4", 1'b1, 14'h24, 8'h04);
        tick_expect("simul_p5", 1'b1, 14'h25, 8'h05);

        // reset mid-frame with CS_n held low
        do_reset();
        cs_low();
        for (int i = 15; i >= 9; i--) spi_bit(1'(16'h0F0F >> i));
        reset_n = 1'b0;
        wait_cyc(2);
        reset_n = 1'b1;
        for (int i = 8; i >= 0; i--) spi_bit(1'(16'h0F0F >> i));
        cs_high(1'b0);
        send_pair(14'h0123, 8'h77);
        chk("midrst_ferr", 32'(bus.frameErrorFlag), 32'd0);
        chk("midrst_level", 32'(bus.fifoLevel), 32'd1);
        tick_expect("midrst", 1'b1, 14'h0123, 8'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
